split_vector: RTL and testbench
===============================

Name: split_vector

Overview:
- Upstream companion of the vector join stage.
- Accepts one full V-element vector (N-bit elements) in a single handshake and emits it as consecutive L-lane chunks, chunk 0 first, one chunk per accepted output beat.
- Output chunk stream feeds the join stage, which reassembles the V-element vector.
- Drives the 4-lane datapath from the vector register file.

Parameters:
- N, 32, element width in bits.
- V, 20, elements per vector.
- L, 4, lanes per chunk.
- C (localparam), ceil(V/L) = 5, number of chunks per vector.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-low (asserted when RST==0, sampled on CLK rising edge).
- vec_valid_i  in  1  input vector valid.
- vec_ready_o  out  1  block can accept a vector this cycle.
- vector_i  in  [V-1:0][N-1:0]  vector to split.
- chunk_valid_o  out  1  chunk_o holds a valid chunk.
- chunk_ready_i  in  1  downstream accepts chunk this cycle.
- chunk_o  out  [L-1:0][N-1:0]  current chunk; lane l = element c*L+l.
- chunk_idx_o  out  $clog2(C)  index c of current chunk.
- last_o  out  1  high when chunk_idx_o == C-1.

Behaviour:
- States: IDLE, SEND.
- Reset (RST==0 at edge):
  - state=IDLE; holding register cleared to 0; chunk counter=0.
  - vec_ready_o=1; chunk_valid_o=0; chunk_o=0; chunk_idx_o=0; last_o=0.
  - Reset mid-SEND discards the vector; no further chunks are emitted.
- IDLE:
  - vec_ready_o=1, chunk_valid_o=0.
  - On vec_valid_i&vec_ready_o: latch vector_i into the holding register, counter=0, go to SEND.
  - First chunk is valid the next cycle (latency 1).
- SEND:
  - chunk_valid_o=1.
  - chunk_o = holding[c*L +: L]; lanes whose element index is >= V output 0.
  - Beat = chunk_valid_o & chunk_ready_i.
  - On a beat with c<C-1: c increments.
  - On a beat with c==C-1: vector complete.
  - chunk_ready_i low: chunk_o, chunk_idx_o and last_o hold stable (no change while stalled).
- Back-to-back:
  - vec_ready_o=1 in SEND only when last_o & chunk_ready_i.
  - New vector accepted in that same cycle: load the holding register, counter=0, stay in SEND. Zero bubble between vectors.
  - Without a new vector: return to IDLE.
- vec_valid_i in SEND while not ready: ignored; upstream must hold.
- V multiple of L: no padding lanes.
- V<=L: C=1; every chunk has last_o=1.

Optional Feature:
- Macro SPLIT_VECTOR_LANE_MASK_EN.
- Defined:
  - Adds output lane_mask_o [L-1:0]; bit l=1 iff c*L+l < V.
  - Reset value 0.
  - For V=20, L=4: always 4'b1111. For V=18: last chunk 4'b0011.
- Undefined:
  - Port absent; padding lanes still forced to 0.

Decomposition:
- Shared package vector_pkg:
  - Function chunks(V,L) returning ceil(V/L).
  - typedef state_t {IDLE, SEND}.
  - Default constants N_DEF=32, V_DEF=20, L_DEF=4, shared with the join stage.
- One sub-module: split_chunk_sel, purely combinational. Selects chunk c from the holding register with zero padding; also produces lane_mask when the macro is enabled.

Test Plan:
- Reset then idle:
  - Stimulus: RST=0 for 2 cycles.
  - Required: all outputs at reset values, vec_ready_o=1.
- Basic split:
  - Stimulus: vector_i[i]=i, chunk_ready_i=1.
  - Required: chunks 1..5 cycles after accept. Chunk c lanes = {4c, 4c+1, 4c+2, 4c+3}; c=4 gives {16,17,18,19} with last_o=1. Then IDLE.
- Backpressure:
  - Stimulus: vector_i[i]=i*5, chunk_ready_i toggled 1,0,0,1,...
  - Required: chunk_o and chunk_idx_o stable while ready=0. Chunk 2 = {40,45,50,55}. Exactly 5 beats total.
- Back-to-back vectors:
  - Stimulus: vector A then vector B, vec_valid_i held high.
  - Required: B accepted on A's last beat. B chunk 0 appears next cycle, no idle cycle. 10 beats in 10 cycles.
- Reset mid-SEND:
  - Stimulus: RST=0 after chunk 2 beat.
  - Required: next cycle chunk_valid_o=0, chunk_idx_o=0. A new vector restarts at chunk 0.
- Padding (V=18):
  - Stimulus: vector_i[i]=i+1.
  - Required: last chunk = {17,18,0,0}; with SPLIT_VECTOR_LANE_MASK_EN defined, lane_mask_o=4'b0011 on that chunk.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared definitions for the vector split/join stages: default geometry, FSM state type,
// and chunk-count helpers.
package vector_pkg;

  localparam int N_DEF = 32;
  localparam int V_DEF = 20;
  localparam int L_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int chunks(input int v, input int l);
    return (v + l - 1) / l;
  endfunction

  // Chunk index width, never narrower than one bit so C==1 still has a port.
  function automatic int idx_w(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

endpackage

// File: rtl/split_vector_if.sv
// Vector-in / chunk-out bus of split_vector; optional lane_mask_o under SPLIT_VECTOR_LANE_MASK_EN.
interface split_vector_if #(
  parameter int N = vector_pkg::N_DEF,
  parameter int V = vector_pkg::V_DEF,
  parameter int L = vector_pkg::L_DEF
);
  localparam int C  = vector_pkg::chunks(V, L);
  localparam int IW = vector_pkg::idx_w(C);

  logic                  vec_valid_i;
  logic                  vec_ready_o;
  logic [V-1:0][N-1:0]   vector_i;
  logic                  chunk_valid_o;
  logic                  chunk_ready_i;
  logic [L-1:0][N-1:0]   chunk_o;
  logic [IW-1:0]         chunk_idx_o;
  logic                  last_o;
`ifdef SPLIT_VECTOR_LANE_MASK_EN
  logic [L-1:0]          lane_mask_o;

  modport slave (
    input  vec_valid_i, vector_i, chunk_ready_i,
    output vec_ready_o, chunk_valid_o, chunk_o, chunk_idx_o, last_o, lane_mask_o
  );
  modport master (
    output vec_valid_i, vector_i, chunk_ready_i,
    input  vec_ready_o, chunk_valid_o, chunk_o, chunk_idx_o, last_o, lane_mask_o
  );
`else
  modport slave (
    input  vec_valid_i, vector_i, chunk_ready_i,
    output vec_ready_o, chunk_valid_o, chunk_o, chunk_idx_o, last_o
  );
  modport master (
    output vec_valid_i, vector_i, chunk_ready_i,
    input  vec_ready_o, chunk_valid_o, chunk_o, chunk_idx_o, last_o
  );
`endif

endinterface

// File: rtl/split_chunk_sel.sv
// Combinational chunk selector: picks chunk i_idx of the held vector, zero-filling lanes past V.
// Emits o_lane_mask only when SPLIT_VECTOR_LANE_MASK_EN is defined.
module split_chunk_sel #(
  parameter int N  = 32,
  parameter int V  = 20,
  parameter int L  = 4,
  parameter int C  = 5,
  parameter int IW = 3
) (
  input  logic [V-1:0][N-1:0]  i_hold,
  input  logic [IW-1:0]        i_idx,
  output logic [L-1:0][N-1:0]  o_chunk
`ifdef SPLIT_VECTOR_LANE_MASK_EN
  ,
  output logic [L-1:0]         o_lane_mask
`endif
);

  // Padded copy so every chunk is a full, constant-base slice.
  logic [C*L-1:0][N-1:0] w_pad;

  always_comb begin
    w_pad         = '0;
    w_pad[V-1:0]  = i_hold;
    o_chunk       = '0;
    for (int c = 0; c < C; c++) begin
      if (i_idx == IW'(c)) o_chunk = w_pad[c*L +: L];
    end
  end

`ifdef SPLIT_VECTOR_LANE_MASK_EN
  always_comb begin
    o_lane_mask = '0;
    for (int c = 0; c < C; c++) begin
      if (i_idx == IW'(c)) begin
        for (int l = 0; l < L; l++) o_lane_mask[l] = ((c*L + l) < V);
      end
    end
  end
`endif

endmodule

// File: rtl/split_vector.sv
// Splits one V-element vector into C consecutive L-lane chunks; first chunk one cycle after accept,
// a new vector is taken on the last beat for zero-bubble streaming. Lane mask under SPLIT_VECTOR_LANE_MASK_EN.
module split_vector
  import vector_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int V = V_DEF,
  parameter int L = L_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  split_vector_if.slave  bus
);

  localparam int C  = chunks(V, L);
  localparam int IW = idx_w(C);

  state_t               r_state, w_state_nxt;
  logic [V-1:0][N-1:0]  r_hold;
  logic [IW-1:0]        r_cnt, w_cnt_nxt;
  logic                 w_load, w_vec_ready, w_send, w_last, w_beat;
  logic [L-1:0][N-1:0]  w_chunk;

  assign w_send = (r_state == SEND);
  assign w_last = w_send && (r_cnt == IW'(C-1));
  assign w_beat = w_send && bus.chunk_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_vec_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_vec_ready = 1'b1;
        if (bus.vec_valid_i) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_beat) begin
          if (w_last) begin
            // Final beat frees the holding register for the next vector in the same cycle.
            w_vec_ready = 1'b1;
            w_cnt_nxt   = '0;
            if (bus.vec_valid_i) w_load      = 1'b1;
            else                 w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) r_hold <= bus.vector_i;
    end
  end

`ifdef SPLIT_VECTOR_LANE_MASK_EN
  logic [L-1:0] w_mask;

  split_chunk_sel #(.N(N), .V(V), .L(L), .C(C), .IW(IW)) u_sel (
    .i_hold      (r_hold),
    .i_idx       (r_cnt),
    .o_chunk     (w_chunk),
    .o_lane_mask (w_mask)
  );

  assign bus.lane_mask_o = w_send ? w_mask : '0;
`else
  split_chunk_sel #(.N(N), .V(V), .L(L), .C(C), .IW(IW)) u_sel (
    .i_hold  (r_hold),
    .i_idx   (r_cnt),
    .o_chunk (w_chunk)
  );
`endif

  assign bus.vec_ready_o   = w_vec_ready;
  assign bus.chunk_valid_o = w_send;
  assign bus.chunk_o       = w_send ? w_chunk : '0;
  assign bus.chunk_idx_o   = r_cnt;
  assign bus.last_o        = w_last;

endmodule

// File: tb/tb_split_vector.sv
// Randomized scoreboard bench for split_vector (V=20 main instance, V=18 padding instance).
module tb_split_vector;
  import vector_pkg::*;

  localparam int N  = 32;
  localparam int V  = 20;
  localparam int L  = 4;
  localparam int C  = chunks(V, L);
  localparam int V2 = 18;
  localparam int C2 = chunks(V2, L);
  localparam int W  = L * N;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  split_vector_if #(.N(N), .V(V),  .L(L)) bus ();
  split_vector_if #(.N(N), .V(V2), .L(L)) bus2 ();

  split_vector #(.N(N), .V(V),  .L(L)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  split_vector #(.N(N), .V(V2), .L(L)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  typedef struct {
    logic [L-1:0][N-1:0] dat;
    int                  idx;
    logic                last;
    logic [L-1:0]        mask;
  } exp_t;

  exp_t sb[$];
  int   beat_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  int   cyc    = 0;
  int   mode   = 0;

  logic                stall = 1'b0;
  logic [L-1:0][N-1:0] s_dat;
  logic [2:0]          s_idx;
  logic                s_last;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Reference: chunk c lane l carries element c*L+l, or zero past the vector end.
  function automatic exp_t model_chunk(input logic [V-1:0][N-1:0] v, input int vl, input int c, input int nc);
    exp_t x;
    for (int l = 0; l < L; l++) begin
      int e;
      e = c * L + l;
      if (e < vl) x.dat[l] = v[e];
      else        x.dat[l] = '0;
      x.mask[l] = (e < vl);
    end
    x.idx  = c;
    x.last = (c == nc - 1);
    return x;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Expected chunks are queued the moment a vector handshake is seen.
  always @(negedge CLK) begin
    if (RST && bus.vec_valid_i && bus.vec_ready_o) begin
      for (int c = 0; c < C; c++) sb.push_back(model_chunk(bus.vector_i, V, c, C));
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      sb.delete();
      stall = 1'b0;
    end else begin
      if (stall && bus.chunk_valid_o) begin
        chk("stall_chunk", bus.chunk_o, s_dat);
        chk("stall_idx", W'(bus.chunk_idx_o), W'(s_idx));
        chk("stall_last", W'(bus.last_o), W'(s_last));
      end
      if (bus.chunk_valid_o && bus.chunk_ready_i) begin
        beats++;
        beat_cyc.push_back(cyc);
        stall = 1'b0;
        if (sb.size() == 0) begin
          fail_now("unexpected_chunk");
        end else begin
          e = sb.pop_front();
          chk("chunk", bus.chunk_o, e.dat);
          chk("idx", W'(bus.chunk_idx_o), W'(e.idx));
          chk("last", W'(bus.last_o), W'(e.last));
`ifdef SPLIT_VECTOR_LANE_MASK_EN
          chk("mask", W'(bus.lane_mask_o), W'(e.mask));
`endif
        end
      end else if (bus.chunk_valid_o) begin
        stall  = 1'b1;
        s_dat  = bus.chunk_o;
        s_idx  = bus.chunk_idx_o;
        s_last = bus.last_o;
      end else begin
        stall = 1'b0;
      end
    end
  end

  // chunk_ready_i patterns: 0 = always ready, 1 = 1,0,0 repeating, 2 = random ~70%.
  initial begin
    int k;
    k = 0;
    bus.chunk_ready_i = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (mode)
        1:       bus.chunk_ready_i = (k % 3 == 0);
        2:       bus.chunk_ready_i = ($urandom_range(0, 9) < 7);
        default: bus.chunk_ready_i = 1'b1;
      endcase
      k++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [V-1:0][N-1:0] v);
    logic acc;
    int   n;
    n = 0;
    bus.vector_i    = v;
    bus.vec_valid_i = 1'b1;
    forever begin
      @(negedge CLK);
      acc = bus.vec_ready_o;
      tick();
      if (acc) break;
      n++;
      if (n > 200) begin
        fail_now("send_timeout");
        break;
      end
    end
    bus.vec_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.chunk_valid_o) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) fail_now("drain_timeout");
  endtask

  function automatic logic [V-1:0][N-1:0] rand_vec();
    logic [V-1:0][N-1:0] v;
    for (int i = 0; i < V; i++) v[i] = $urandom;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [V-1:0][N-1:0]  v;
    logic [V2-1:0][N-1:0] v2;
    int b0;
    int n;
    exp_t x;

    bus.vec_valid_i  = 1'b0;
    bus.vector_i     = '0;
    bus2.vec_valid_i = 1'b0;
    bus2.vector_i    = '0;
    bus2.chunk_ready_i = 1'b1;
    RST = 1'b0;
    repeat (2) tick();

    @(negedge CLK);
    chk("rst_vec_ready", W'(bus.vec_ready_o), W'(1));
    chk("rst_chunk_valid", W'(bus.chunk_valid_o), W'(0));
    chk("rst_chunk", bus.chunk_o, '0);
    chk("rst_idx", W'(bus.chunk_idx_o), W'(0));
    chk("rst_last", W'(bus.last_o), W'(0));
`ifdef SPLIT_VECTOR_LANE_MASK_EN
    chk("rst_mask", W'(bus.lane_mask_o), W'(0));
`endif
    tick();
    RST = 1'b1;
    tick();

    // Basic split, latency and return to idle.
    mode = 0;
    for (int i = 0; i < V; i++) v[i] = i;
    send(v);
    @(negedge CLK);
    chk("first_latency", W'(bus.chunk_valid_o), W'(1));
    drain();
    @(negedge CLK);
    chk("idle_ready", W'(bus.vec_ready_o), W'(1));
    chk("idle_valid", W'(bus.chunk_valid_o), W'(0));
    tick();

    // Backpressure: exactly C beats.
    mode = 1;
    for (int i = 0; i < V; i++) v[i] = i * 5;
    b0 = beats;
    send(v);
    drain();
    chk("bp_beats", W'(beats - b0), W'(C));

    // Back-to-back: 2*C beats in 2*C consecutive cycles.
    mode = 0;
    tick();
    b0 = beats;
    send(rand_vec());
    send(rand_vec());
    drain();
    chk("b2b_beats", W'(beats - b0), W'(2 * C));
    chk("b2b_span", W'(beat_cyc[$] - beat_cyc[$ - (2*C - 1)]), W'(2 * C - 1));

    // Reset after the chunk-2 beat.
    send(rand_vec());
    n = 0;
    forever begin
      @(negedge CLK);
      if (bus.chunk_valid_o && bus.chunk_ready_i && bus.chunk_idx_o == 3'd2) break;
      n++;
      if (n > 50) begin
        fail_now("wait_chunk2_timeout");
        break;
      end
    end
    tick();
    RST = 1'b0;
    tick();
    @(negedge CLK);
    chk("midrst_valid", W'(bus.chunk_valid_o), W'(0));
    chk("midrst_idx", W'(bus.chunk_idx_o), W'(0));
    tick();
    RST = 1'b1;
    tick();
    send(rand_vec());
    drain();

    // Randomized traffic.
    mode = 2;
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(rand_vec());
    end
    drain();
    mode = 0;

    // Padding instance, V=18.
    for (int i = 0; i < V2; i++) v2[i] = i + 1;
    for (int i = 0; i < V; i++) v[i] = '0;
    v[V2-1:0] = v2;
    bus2.vector_i    = v2;
    bus2.vec_valid_i = 1'b1;
    @(negedge CLK);
    chk("pad_ready", W'(bus2.vec_ready_o), W'(1));
    tick();
    bus2.vec_valid_i = 1'b0;
    for (int c = 0; c < C2; c++) begin
      x = model_chunk(v, V2, c, C2);
      @(negedge CLK);
      chk("pad_valid", W'(bus2.chunk_valid_o), W'(1));
      chk("pad_idx", W'(bus2.chunk_idx_o), W'(x.idx));
      chk("pad_chunk", bus2.chunk_o, x.dat);
      chk("pad_last", W'(bus2.last_o), W'(x.last));
`ifdef SPLIT_VECTOR_LANE_MASK_EN
      chk("pad_mask", W'(bus2.lane_mask_o), W'(x.mask));
`endif
      tick();
    end
    @(negedge CLK);
    chk("pad_done", W'(bus2.chunk_valid_o), W'(0));

    if (sb.size() != 0) fail_now("scoreboard_leftover");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
